// File: rtl/neuron_accumulator.sv
// Per-lane signed accumulator: sums NP consecutive input beats of NC lanes and
// presents the full-width result vector on a valid/ready output.
module neuron_accumulator #(
  parameter int unsigned NP    = 4,
  parameter int unsigned NC    = 4,
  parameter int unsigned WF    = 4,
  parameter string       BURST = "yes"
) (
  input  logic                               iCLK,
  input  logic                               iRST,
  input  logic                               iValid_AM_Prod0,
  output logic                               oReady_AM_Prod0,
  input  logic [NC*WF-1:0]                   iData_AM_Prod0,
  output logic                               oValid_BM_Accum0,
  input  logic                               iReady_BM_Accum0,
  output logic [NC*($clog2(NP)+WF)-1:0]      oData_BM_Accum0
);

  localparam int unsigned CW       = $clog2(NP);
  localparam int unsigned WA       = CW + WF;
  localparam bit          BURST_EN = (BURST == "yes");

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_valid;
  logic [WA-1:0]   r_acc  [NC];
  logic [WA-1:0]   w_sext [NC];
  logic            w_in_xfer;
  logic            w_out_xfer;

  // Sign-extend each incoming lane product to accumulator width
  always_comb begin
    for (int c = 0; c < NC; c++) begin
      w_sext[c] = {{CW{iData_AM_Prod0[c*WF+WF-1]}}, iData_AM_Prod0[c*WF +: WF]};
    end
  end

  // In burst mode a held result can be drained and replaced in the same cycle
  assign oReady_AM_Prod0  = (r_state == ACCUM) || (BURST_EN && iReady_BM_Accum0);
  assign oValid_BM_Accum0 = r_valid;
  assign w_in_xfer        = iValid_AM_Prod0 && oReady_AM_Prod0;
  assign w_out_xfer       = r_valid && iReady_BM_Accum0;

  for (genvar c = 0; c < NC; c++) begin : g_out
    assign oData_BM_Accum0[c*WA +: WA] = r_acc[c];
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_state <= ACCUM;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      for (int c = 0; c < NC; c++) r_acc[c] <= '0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (w_in_xfer) begin
            // First beat of a vector overwrites the previous sum
            for (int c = 0; c < NC; c++) begin
              r_acc[c] <= (r_cnt == '0) ? w_sext[c] : WA'(r_acc[c] + w_sext[c]);
            end
            if (r_cnt == CW'(NP - 1)) begin
              r_cnt   <= '0;
              r_state <= HOLD;
              r_valid <= 1'b1;
            end else begin
              r_cnt <= CW'(r_cnt + CW'(1));
            end
          end
        end
        HOLD: begin
          if (w_out_xfer) begin
            r_state <= ACCUM;
            r_valid <= 1'b0;
            if (w_in_xfer) begin
              for (int c = 0; c < NC; c++) r_acc[c] <= w_sext[c];
              r_cnt <= CW'(1);
            end else begin
              r_cnt <= '0;
            end
          end
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_accumulator.sv
// Self-checking bench for neuron_accumulator: burst and non-burst instances
// compared against an integer-sum reference model.
module tb_neuron_accumulator;

  localparam int NP = 4;
  localparam int NC = 2;
  localparam int WF = 4;
  localparam int WA = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // index 0: BURST="yes", index 1: BURST="no"
  logic               v_in  [2];
  logic [NC*WF-1:0]   d_in  [2];
  logic               r_in  [2];
  logic               o_rdy [2];
  logic               o_vld [2];
  logic [NC*WA-1:0]   o_dat [2];

  neuron_accumulator #(.NP(NP), .NC(NC), .WF(WF), .BURST("yes")) u_y (
    .iCLK(clk), .iRST(rst),
    .iValid_AM_Prod0(v_in[0]), .oReady_AM_Prod0(o_rdy[0]), .iData_AM_Prod0(d_in[0]),
    .oValid_BM_Accum0(o_vld[0]), .iReady_BM_Accum0(r_in[0]), .oData_BM_Accum0(o_dat[0])
  );

  neuron_accumulator #(.NP(NP), .NC(NC), .WF(WF), .BURST("no")) u_n (
    .iCLK(clk), .iRST(rst),
    .iValid_AM_Prod0(v_in[1]), .oReady_AM_Prod0(o_rdy[1]), .iData_AM_Prod0(d_in[1]),
    .oValid_BM_Accum0(o_vld[1]), .iReady_BM_Accum0(r_in[1]), .oData_BM_Accum0(o_dat[1])
  );

  int checks = 0;
  int errors = 0;

  // Reference model: running integer sums, beat count, and a held result
  int m_sum  [2][NC];
  int m_held [2][NC];
  int m_n    [2];
  bit m_hold [2];

  // Expected and observed outputs for the most recent cycle
  bit               e_vld, e_rdy;
  logic [NC*WA-1:0] e_dat;
  logic             s_vld, s_rdy;
  logic [NC*WA-1:0] s_dat;

  function automatic int rnd_prod();
    return int'($urandom_range(0, 15)) - 8;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_n[m] = 0;
      m_hold[m] = 1'b0;
      for (int c = 0; c < NC; c++) begin
        m_sum[m][c] = 0;
        m_held[m][c] = 0;
      end
    end
  endtask

  // Drive one cycle on instance m (the other instance idles), capture outputs,
  // then advance the model across the following clock edge.
  task automatic tick(input int m, input bit v, input int a0, input int a1, input bit r);
    @(negedge clk);
    v_in[1-m] = 1'b0;
    r_in[1-m] = 1'b0;
    v_in[m]   = v;
    d_in[m]   = {4'(a1), 4'(a0)};
    r_in[m]   = r;
    #1;
    e_vld = m_hold[m];
    e_rdy = !m_hold[m] || (m == 0 && r);
    e_dat = {6'(m_held[m][1]), 6'(m_held[m][0])};
    s_vld = o_vld[m];
    s_rdy = o_rdy[m];
    s_dat = o_dat[m];
    if (m_hold[m] && r) m_hold[m] = 1'b0;
    if (v && e_rdy) begin
      m_sum[m][0] += a0;
      m_sum[m][1] += a1;
      m_n[m]++;
      if (m_n[m] == NP) begin
        for (int c = 0; c < NC; c++) begin
          m_held[m][c] = m_sum[m][c];
          m_sum[m][c]  = 0;
        end
        m_hold[m] = 1'b1;
        m_n[m] = 0;
      end
    end
  endtask

  // Reset with a beat presented on both inputs; that beat must be ignored
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      v_in[m] = 1'b1;
      r_in[m] = 1'b0;
      d_in[m] = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int m = 0; m < 2; m++) v_in[m] = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int m = 0; m < 2; m++) begin
      if (o_vld[m] !== 1'b0 || o_rdy[m] !== 1'b1 || o_dat[m] !== '0) begin
        errors++;
        $display("FAIL reset m%0d: got v=%0b r=%0b d=%h required v=0 r=1 d=000",
                 m, o_vld[m], o_rdy[m], o_dat[m]);
      end
      checks++;
    end
  endtask

  task automatic test_extremes();
    do_reset();
    for (int i = 0; i < NP + 2; i++) begin
      tick(0, i < NP, 7, -8, 1'b1);
      if (s_vld !== e_vld || s_rdy !== e_rdy || (e_vld && s_dat !== e_dat)) begin
        errors++;
        $display("FAIL extremes cyc%0d: got v=%0b r=%0b d=%h required v=%0b r=%0b d=%h",
                 i, s_vld, s_rdy, s_dat, e_vld, e_rdy, e_dat);
      end
      checks++;
      if (i == NP) begin
        if (s_vld !== 1'b1 || s_dat !== 12'b100000_011100) begin
          errors++;
          $display("FAIL extremes_value: got v=%0b d=%h required v=1 d=%h", s_vld, s_dat, 12'b100000_011100);
        end
        checks++;
      end
      if (i == NP + 1) begin
        if (s_vld !== 1'b0) begin
          errors++;
          $display("FAIL extremes_onecycle: got v=%0b required v=0", s_vld);
        end
        checks++;
      end
    end
  endtask

  task automatic test_mixed_signs();
    int l0 [8] = '{3, -5, 2, -1, 1, 1, 1, 1};
    int l1 [8] = '{-8, 7, -8, 7, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4)      tick(0, 1'b1, l0[i], l1[i], 1'b0);
      else if (i == 4) tick(0, 1'b0, 0, 0, 1'b1);
      else if (i < 9) tick(0, 1'b1, l0[i-1], l1[i-1], 1'b0);
      else            tick(0, 1'b0, 0, 0, 1'b1);
      if (s_vld !== e_vld || s_rdy !== e_rdy || (e_vld && s_dat !== e_dat)) begin
        errors++;
        $display("FAIL mixed cyc%0d: got v=%0b r=%0b d=%h required v=%0b r=%0b d=%h",
                 i, s_vld, s_rdy, s_dat, e_vld, e_rdy, e_dat);
      end
      checks++;
      if (i == 4 && s_dat !== {6'(-2), 6'(-1)}) begin
        errors++;
        $display("FAIL mixed_value: got d=%h required d=%h", s_dat, {6'(-2), 6'(-1)});
      end
      if (i == 9 && s_dat !== {6'd4, 6'd4}) begin
        errors++;
        $display("FAIL no_carry_over: got d=%h required d=%h", s_dat, {6'd4, 6'd4});
      end
      if (i == 4 || i == 9) checks++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < NP + 10 + NP + 1; i++) begin
      if (i < NP)            tick(0, 1'b1, rnd_prod(), rnd_prod(), 1'b0);
      else if (i < NP + 10)  tick(0, 1'b1, rnd_prod(), rnd_prod(), 1'b0);
      else if (i < 2*NP + 10) tick(0, 1'b1, rnd_prod(), rnd_prod(), 1'b1);
      else                   tick(0, 1'b0, 0, 0, 1'b1);
      if (s_vld !== e_vld || s_rdy !== e_rdy || (e_vld && s_dat !== e_dat)) begin
        errors++;
        $display("FAIL backpressure cyc%0d: got v=%0b r=%0b d=%h required v=%0b r=%0b d=%h",
                 i, s_vld, s_rdy, s_dat, e_vld, e_rdy, e_dat);
      end
      checks++;
    end
  endtask

  task automatic test_back_to_back();
    int pulses [$];
    int ncyc;
    for (int m = 0; m < 2; m++) begin
      do_reset();
      pulses.delete();
      ncyc = (m == 0) ? 3*NP + 1 : 3*(NP+1);
      for (int i = 0; i < ncyc; i++) begin
        tick(m, 1'b1, rnd_prod(), rnd_prod(), 1'b1);
        if (s_vld === 1'b1) pulses.push_back(i);
        if (s_vld !== e_vld || s_rdy !== e_rdy || (e_vld && s_dat !== e_dat)) begin
          errors++;
          $display("FAIL back_to_back m%0d cyc%0d: got v=%0b r=%0b d=%h required v=%0b r=%0b d=%h",
                   m, i, s_vld, s_rdy, s_dat, e_vld, e_rdy, e_dat);
        end
        checks++;
      end
      if (pulses.size() != 3) begin
        errors++;
        $display("FAIL pulse_count m%0d: got %0d required 3", m, pulses.size());
      end else if (pulses[1] - pulses[0] != NP + m || pulses[2] - pulses[1] != NP + m) begin
        errors++;
        $display("FAIL pulse_spacing m%0d: got %0d,%0d required %0d", m,
                 pulses[1] - pulses[0], pulses[2] - pulses[1], NP + m);
      end
      checks++;
    end
  endtask

  task automatic test_gapped();
    for (int m = 0; m < 2; m++) begin
      do_reset();
      for (int i = 0; i < 200; i++) begin
        tick(m, 1'($urandom), rnd_prod(), rnd_prod(), 1'($urandom));
        if (s_vld !== e_vld || s_rdy !== e_rdy || (e_vld && s_dat !== e_dat)) begin
          errors++;
          $display("FAIL gapped m%0d cyc%0d: got v=%0b r=%0b d=%h required v=%0b r=%0b d=%h",
                   m, i, s_vld, s_rdy, s_dat, e_vld, e_rdy, e_dat);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    tick(0, 1'b1, 5, 5, 1'b0);
    tick(0, 1'b1, 5, 5, 1'b0);
    do_reset();
    for (int i = 1; i <= NP; i++) tick(0, 1'b1, i, i, 1'b0);
    tick(0, 1'b0, 0, 0, 1'b0);
    if (s_vld !== 1'b1 || s_dat !== {6'd10, 6'd10}) begin
      errors++;
      $display("FAIL reset_partial: got v=%0b d=%h required v=1 d=%h", s_vld, s_dat, {6'd10, 6'd10});
    end
    checks++;
    do_reset();
    if (o_vld[0] !== 1'b0 || o_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_hold: got v=%0b r=%0b required v=0 r=1", o_vld[0], o_rdy[0]);
    end
    checks++;
  endtask

  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      v_in[m] = 1'b0;
      r_in[m] = 1'b0;
      d_in[m] = '0;
    end
    model_reset();
    test_reset();
    test_extremes();
    test_mixed_signs();
    test_backpressure();
    test_back_to_back();
    test_gapped();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
